vend_timeout_timer: RTL and testbench
=====================================

Name: vend_timeout_timer

Overview:
Countdown timer for vending-machine timeouts, such as the change-return and selection windows. It receives the divided 1 kHz square wave `clk_1k` produced by the clock divider and synchronizes it into the system domain. Each rising edge becomes a one-cycle tick, and it counts down a loaded number of seconds. It is the consumer end of the divider output, sitting between the divider and the vending FSM, which starts, pauses and cancels it and reacts to `done`.

Parameters:
MS_PER_SEC, 1000, `clk_1k` rising edges per decremented second (>=2)
SEC_W, 8, width of second counter and load value
WARN_SEC, 3, warning threshold in seconds (used only with TIMER_WARN_EN)

Ports:
clk       in   1      system clock; the only clock
rst       in   1      asynchronous active-low reset
clk_1k    in   1      divided clock from divider, sampled as data
start     in   1      1-cycle pulse; load and (re)start countdown
load_sec  in   SEC_W  seconds to count, sampled when start=1
pause     in   1      level; while 1, ticks are ignored
cancel    in   1      1-cycle pulse; abort without done
busy      out  1      1 while counting (RUN or PAUSE)
sec_left  out  SEC_W  seconds remaining
done      out  1      1-cycle pulse at expiry
warn      out  1      only with TIMER_WARN_EN

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; busy=0, sec_left=0, done=0, warn=0.
  - ms counter=0; both synchronizer flops and the edge-history flop cleared to 0.
- Tick generation:
  - `clk_1k` passes through a 2-flop synchronizer, then a history flop.
  - tick = sync_q & ~hist_q.
  - tick is 1 cycle wide, asserted on the 3rd clk rising edge after `clk_1k` rises.
  - A `clk_1k` already high at reset release yields one tick; it is harmless in IDLE.
- ms counter:
  - width clog2(MS_PER_SEC); counts ticks only in RUN.
  - wraps MS_PER_SEC-1 -> 0.
- States: IDLE, RUN, PAUSE. busy = (state != IDLE).
- Per-cycle priority: cancel > start > pause > tick.
- IDLE:
  - start & load_sec!=0: -> RUN; sec_left=load_sec, ms=0.
  - start & load_sec==0: done=1 next cycle; stay IDLE.
- RUN:
  - cancel: -> IDLE; sec_left=0, ms=0, no done.
  - start: reload as in IDLE (restart); no done for the aborted run.
  - pause=1: -> PAUSE; a tick in the same cycle is dropped.
  - tick & ms<MS_PER_SEC-1: ms++.
  - tick & ms==MS_PER_SEC-1: ms=0, sec_left--.
    - If sec_left was 1: sec_left=0, done=1 for one cycle, -> IDLE.
    - busy and done change on the same edge.
- PAUSE:
  - ms and sec_left frozen; ticks dropped.
  - pause=0: -> RUN next cycle.
  - cancel and start behave as in RUN.
- sec_left never underflows. done never asserts for two consecutive cycles.
- Latency: expiry occurs on the 3rd clk edge after the (load_sec*MS_PER_SEC)-th counted `clk_1k` rising edge.
- All outputs are registered.

Optional Feature:
TIMER_WARN_EN:
- Defined: port `warn` exists. warn=1 (registered) while state==RUN or PAUSE and 0 < sec_left <= WARN_SEC; 0 otherwise, including IDLE and reset. The FSM uses it to blink a "hurry" LED.
- Undefined: `warn` port and its logic are absent. All other behaviour is identical.

Test Plan:
1. Reset: drive rst=0 with `clk_1k` toggling -> busy=0, sec_left=0, done=0 immediately and for the whole reset; release rst -> still idle, no done.
2. Normal expiry (MS_PER_SEC=4, `clk_1k` toggles every 5 clk): load_sec=3, start pulse -> busy=1 next cycle, sec_left=3. sec_left steps 3->2->1 after the 4th and 8th edges; the 12th edge gives sec_left=0, done=1 for exactly one cycle, busy=0 on the same edge.
3. Pause: run load_sec=2, hold pause across 6 `clk_1k` edges after the 2nd counted edge -> sec_left=2 frozen. Release -> done after 6 further edges (8 counted total).
4. Cancel and restart: load_sec=5, cancel after 5 edges -> busy=0, sec_left=0, no done ever. Then start with load_sec=1 -> done after 4 edges. Start during RUN reloads sec_left to load_sec.
5. Zero load: start with load_sec=0 -> done=1 exactly one cycle later, busy stays 0.
6. Async reset mid-run: rst=0 mid-cycle during RUN with sec_left=4 -> outputs cleared before the next clk edge. After release, `clk_1k` edges cause no counting.

Source files
------------

// File: rtl/vend_timeout_timer.sv
// Countdown timer for vending timeouts, paced by the divided 1 kHz clock.
// Optional warning output enabled by defining TIMER_WARN_EN.
module vend_timeout_timer #(
  parameter int MS_PER_SEC = 1000,
  parameter int SEC_W      = 8,
  parameter int WARN_SEC   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_1k,
  input  logic             start,
  input  logic [SEC_W-1:0] load_sec,
  input  logic             pause,
  input  logic             cancel,
  output logic             busy,
  output logic [SEC_W-1:0] sec_left,
  output logic             done
`ifdef TIMER_WARN_EN
  ,
  output logic             warn
`endif
);

  localparam int MS_W = $clog2(MS_PER_SEC);
  localparam logic [MS_W-1:0] MS_MAX = MS_W'(MS_PER_SEC - 1);

  if (MS_PER_SEC < 2 || WARN_SEC < 0) begin : g_bad_param
    $error("vend_timeout_timer: bad parameter");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE
  } state_t;

  state_t          state;
  logic [MS_W-1:0] ms;
  logic            sync1;
  logic            sync2;
  logic            hist;
  logic            tick;

  // clk_1k is asynchronous data; two flops then edge history
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= clk_1k;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign tick = sync2 & ~hist;

`ifdef TIMER_WARN_EN
  function automatic logic in_warn(input logic [SEC_W-1:0] s);
    return (s != '0) && (s <= SEC_W'(WARN_SEC));
  endfunction
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ms       <= '0;
      busy     <= 1'b0;
      sec_left <= '0;
      done     <= 1'b0;
`ifdef TIMER_WARN_EN
      warn     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (cancel) begin
        state    <= IDLE;
        busy     <= 1'b0;
        sec_left <= '0;
        ms       <= '0;
`ifdef TIMER_WARN_EN
        warn     <= 1'b0;
`endif
      end else if (start) begin
        ms <= '0;
        if (load_sec != '0) begin
          state    <= RUN;
          busy     <= 1'b1;
          sec_left <= load_sec;
`ifdef TIMER_WARN_EN
          warn     <= in_warn(load_sec);
`endif
        end else begin
          // zero load expires at once, also when restarting a run
          state    <= IDLE;
          busy     <= 1'b0;
          sec_left <= '0;
          done     <= 1'b1;
`ifdef TIMER_WARN_EN
          warn     <= 1'b0;
`endif
        end
      end else begin
        unique case (state)
          IDLE: begin
          end
          RUN: begin
            if (pause) begin
              state <= PAUSE;
            end else if (tick) begin
              if (ms == MS_MAX) begin
                ms       <= '0;
                sec_left <= sec_left - SEC_W'(1);
                if (sec_left == SEC_W'(1)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
`ifdef TIMER_WARN_EN
                  warn  <= 1'b0;
`endif
                end else begin
`ifdef TIMER_WARN_EN
                  warn  <= in_warn(sec_left - SEC_W'(1));
`endif
                end
              end else begin
                ms <= ms + MS_W'(1);
              end
            end
          end
          PAUSE: begin
            if (!pause) state <= RUN;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vend_timeout_timer.sv
// Bench for vend_timeout_timer: directed scenarios then random traffic,
// every cycle compared with a tick-budget reference model.
module tb_vend_timeout_timer;

  localparam int MS    = 4;
  localparam int SEC_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             clk_1k;
  logic             start;
  logic [SEC_W-1:0] load_sec;
  logic             pause;
  logic             cancel;
  logic             busy;
  logic [SEC_W-1:0] sec_left;
  logic             done;

  vend_timeout_timer #(
    .MS_PER_SEC(MS),
    .SEC_W     (SEC_W),
    .WARN_SEC  (3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .clk_1k  (clk_1k),
    .start   (start),
    .load_sec(load_sec),
    .pause   (pause),
    .cancel  (cancel),
    .busy    (busy),
    .sec_left(sec_left),
    .done    (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int done_obs = 0;
  int div_cnt = 0;
  bit rand_mode = 0;

  // Reference: remaining counted ticks; seconds are derived by rounding up
  bit m_busy, m_paused, m_done;
  int m_left, m_ticks;
  bit p1, p2, p3;

  function automatic int m_sec();
    return m_busy ? (m_left + MS - 1) / MS : 0;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_paused = 0; m_done = 0;
    m_left = 0; m_ticks = 0;
    p1 = 0; p2 = 0; p3 = 0;
  endtask

  task automatic model_edge();
    bit tk;
    if (!rst) begin
      model_reset();
      return;
    end
    tk = p2 & ~p3;
    p3 = p2; p2 = p1; p1 = clk_1k;
    m_done = 0;
    if (cancel) begin
      m_busy = 0; m_left = 0; m_paused = 0;
    end else if (start) begin
      m_paused = 0; m_ticks = 0;
      if (load_sec != 0) begin
        m_busy = 1; m_left = int'(load_sec) * MS;
      end else begin
        m_busy = 0; m_left = 0; m_done = 1;
      end
    end else if (m_busy) begin
      if (m_paused) begin
        if (!pause) m_paused = 0;
      end else if (pause) begin
        m_paused = 1;
      end else if (tk) begin
        m_left--; m_ticks++;
        if (m_left == 0) begin
          m_busy = 0; m_done = 1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("busy", int'(busy), int'(m_busy));
    chk("sec_left", int'(sec_left), m_sec());
    chk("done", int'(done), int'(m_done));
    if (done === 1'b1) done_obs++;
    start = 0;
    cancel = 0;
    if (rand_mode) begin
      if ($urandom_range(0, 2) == 0) clk_1k = ~clk_1k;
    end else begin
      div_cnt++;
      if (div_cnt >= 5) begin
        div_cnt = 0;
        clk_1k = ~clk_1k;
      end
    end
  endtask

  task automatic run_until_done(input int limit);
    for (int i = 0; i < limit; i++) begin
      step();
      if (done === 1'b1) return;
    end
  endtask

  task automatic run_until_ticks(input int n, input int limit);
    for (int i = 0; i < limit && m_ticks < n; i++) step();
  endtask

  initial begin
    model_reset();
    rst = 0; clk_1k = 0; start = 0; cancel = 0;
    pause = 0; load_sec = '0;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_sec", int'(sec_left), 0);
    chk("rst_done", int'(done), 0);
    repeat (12) step();
    rst = 1;
    repeat (20) step();
    chk("idle_done_cnt", done_obs, 0);

    // normal expiry
    load_sec = 3; start = 1;
    step();
    chk("run_busy", int'(busy), 1);
    chk("run_sec", int'(sec_left), 3);
    done_obs = 0;
    run_until_done(400);
    chk("expire_done", int'(done), 1);
    chk("expire_busy", int'(busy), 0);
    step();
    chk("expire_pulse", done_obs, 1);

    // pause
    load_sec = 2; start = 1;
    step();
    run_until_ticks(2, 200);
    pause = 1;
    repeat (60) step();
    chk("pause_sec", int'(sec_left), 2);
    chk("pause_busy", int'(busy), 1);
    pause = 0;
    done_obs = 0;
    run_until_done(400);
    chk("pause_expire", int'(done), 1);

    // cancel, restart, reload
    load_sec = 5; start = 1;
    step();
    run_until_ticks(5, 200);
    cancel = 1;
    step();
    chk("cancel_busy", int'(busy), 0);
    chk("cancel_sec", int'(sec_left), 0);
    done_obs = 0;
    repeat (80) step();
    chk("cancel_no_done", done_obs, 0);
    load_sec = 1; start = 1;
    step();
    run_until_done(200);
    chk("one_sec_done", int'(done), 1);
    load_sec = 5; start = 1;
    step();
    repeat (25) step();
    load_sec = 3; start = 1;
    step();
    chk("reload_sec", int'(sec_left), 3);

    // zero load
    cancel = 1;
    step();
    load_sec = 0; start = 1;
    step();
    chk("zero_done", int'(done), 1);
    chk("zero_busy", int'(busy), 0);
    step();
    chk("zero_pulse_end", int'(done), 0);

    // async reset mid-run
    load_sec = 4; start = 1;
    step();
    repeat (3) step();
    chk("pre_rst_sec", int'(sec_left), 4);
    #2 rst = 0;
    model_reset();
    #1;
    chk("async_busy", int'(busy), 0);
    chk("async_sec", int'(sec_left), 0);
    chk("async_done", int'(done), 0);
    repeat (4) step();
    rst = 1;
    done_obs = 0;
    repeat (60) step();
    chk("post_rst_sec", int'(sec_left), 0);
    chk("post_rst_done", done_obs, 0);

    // random traffic
    rand_mode = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        start = 1;
        load_sec = SEC_W'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 149) == 0) cancel = 1;
      if ($urandom_range(0, 29) == 0) pause = ~pause;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
